// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and helpers for display blocks.
// Segment bit order is bit0=A .. bit6=G, active-high.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Pure combinational hex nibble to seven-segment decoder.
module hex_to_7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_Nibble,
  output logic [6:0] o_Segments
);

  always_comb begin
    o_Segments = SEG_BLANK;
    case (i_Nibble)
      4'h0: o_Segments = SEG_0;
      4'h1: o_Segments = SEG_1;
      4'h2: o_Segments = SEG_2;
      4'h3: o_Segments = SEG_3;
      4'h4: o_Segments = SEG_4;
      4'h5: o_Segments = SEG_5;
      4'h6: o_Segments = SEG_6;
      4'h7: o_Segments = SEG_7;
      4'h8: o_Segments = SEG_8;
      4'h9: o_Segments = SEG_9;
      4'hA: o_Segments = SEG_A;
      4'hB: o_Segments = SEG_B;
      4'hC: o_Segments = SEG_C;
      4'hD: o_Segments = SEG_D;
      4'hE: o_Segments = SEG_E;
      default: o_Segments = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 7-segment scan driver with blanking, per-digit enable and frame-synchronous update.
// Optional LEADING_ZERO_BLANK_EN blanks enabled leading-zero digits, mask computed at commit.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic                    i_Load,
  input  logic [NUM_DIGITS-1:0]   i_Digit_En,
  output logic [6:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digit_Sel,
  output logic                    o_Frame_Done,
  output logic                    o_Busy_Pending
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int PRE_W = idx_width(REFRESH_DIV);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      LAST_PRE  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0]      BLANK_END = PRE_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE  = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PRE_W-1:0]        r_prescaler;
  logic [IDX_W-1:0]        r_index;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_en;
  logic                    r_pend_flag;
  logic [4*NUM_DIGITS-1:0] r_disp_value;
  logic [NUM_DIGITS-1:0]   r_disp_en;
  logic [6:0]              r_segments;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_blank;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_next_value;
  logic [NUM_DIGITS-1:0]   w_next_en;
  logic [3:0]              w_nibble;
  logic [6:0]              w_decoded;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_show;

  assign w_slot_end = (r_prescaler == LAST_PRE);
  assign w_boundary = w_slot_end && (r_index == LAST_IDX);
  assign w_blank    = (r_prescaler < BLANK_END);

  // A load arriving exactly on the boundary bypasses the pending register.
  assign w_commit     = w_boundary && (i_Load || r_pend_flag);
  assign w_next_value = i_Load ? i_Value    : r_pend_value;
  assign w_next_en    = i_Load ? i_Digit_En : r_pend_en;

  assign w_nibble = r_disp_value[{r_index, 2'b00} +: 4];
  assign w_onehot = NUM_DIGITS'(1) << r_index;

  hex_to_7seg u_dec (
    .i_Nibble   (w_nibble),
    .o_Segments (w_decoded)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] r_lzb_mask;
  logic [NUM_DIGITS-1:0] w_lzb_mask;

  // Digits stay lit from the highest non-zero enabled nibble down; digit 0 always lit.
  always_comb begin
    logic v_found;
    v_found    = 1'b0;
    w_lzb_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (w_next_en[k] && (w_next_value[4*k +: 4] != 4'h0)) v_found = 1'b1;
      w_lzb_mask[k] = v_found || (k == 0);
    end
  end

  assign w_show = r_disp_en[r_index] && r_lzb_mask[r_index];
`else
  assign w_show = r_disp_en[r_index];
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_prescaler  <= '0;
      r_index      <= '0;
      r_pend_value <= '0;
      r_pend_en    <= '0;
      r_pend_flag  <= 1'b0;
      r_disp_value <= '0;
      r_disp_en    <= '0;
      r_segments   <= SEG_BLANK;
      r_digit_sel  <= SEL_IDLE;
      r_frame_done <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_lzb_mask   <= '0;
`endif
    end else begin
      if (w_slot_end) begin
        r_prescaler <= '0;
        r_index     <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end

      if (i_Load) begin
        r_pend_value <= i_Value;
        r_pend_en    <= i_Digit_En;
      end

      if (w_commit) begin
        r_disp_value <= w_next_value;
        r_disp_en    <= w_next_en;
`ifdef LEADING_ZERO_BLANK_EN
        r_lzb_mask   <= w_lzb_mask;
`endif
      end

      r_pend_flag  <= w_boundary ? 1'b0 : (r_pend_flag | i_Load);
      r_frame_done <= w_boundary;

      // Segments and selects always move together on the same edge.
      if (w_blank) begin
        r_segments  <= SEG_BLANK;
        r_digit_sel <= SEL_IDLE;
      end else begin
        r_segments  <= w_show ? w_decoded : SEG_BLANK;
        r_digit_sel <= w_onehot ^ SEL_IDLE;
      end
    end
  end

  assign o_Segments     = r_segments;
  assign o_Digit_Sel    = r_digit_sel;
  assign o_Frame_Done   = r_frame_done;
  assign o_Busy_Pending = r_pend_flag;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seven_seg_scan_driver;

  localparam int ND = 4;

  logic          clk;
  logic          rst_n;
  logic [4*ND-1:0] value;
  logic          load;
  logic [ND-1:0] digit_en;
  logic [6:0]    segments;
  logic [ND-1:0] digit_sel;
  logic          frame_done;
  logic          busy_pending;

  int n_checks;
  int n_fail;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEL_ACTIVE_LOW (0)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Value        (value),
    .i_Load         (load),
    .i_Digit_En     (digit_en),
    .o_Segments     (segments),
    .o_Digit_Sel    (digit_sel),
    .o_Frame_Done   (frame_done),
    .o_Busy_Pending (busy_pending)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en);
    value    = v;
    digit_en = en;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  // Called right after the edge that shows o_Frame_Done; walks one full frame.
  // exp_segs packs {d3,d2,d1,d0}, 7 bits each.
  task automatic check_frame(input string name, input logic [27:0] exp_segs);
    for (int d = 0; d < ND; d++) begin
      tick();
      check($sformatf("%s_d%0d_blank_sel", name, d), {28'd0, digit_sel}, 32'd0);
      check($sformatf("%s_d%0d_blank_seg", name, d), {25'd0, segments}, 32'd0);
      for (int j = 0; j < 3; j++) begin
        tick();
        check($sformatf("%s_d%0d_sel", name, d), {28'd0, digit_sel}, 32'd1 << d);
        check($sformatf("%s_d%0d_seg", name, d), {25'd0, segments}, {25'd0, exp_segs[7*d +: 7]});
      end
    end
    check($sformatf("%s_frame_done", name), {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    value    = '0;
    load     = 1'b0;
    digit_en = '0;

    // Reset state
    #2;
    check("rst_seg",  {25'd0, segments}, 32'd0);
    check("rst_sel",  {28'd0, digit_sel}, 32'd0);
    check("rst_fd",   {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy_pending}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic display of 12AF
    do_load(16'h12AF, 4'hF);
    check("t1_busy", {31'd0, busy_pending}, 32'd1);
    wait_frame_done();
    check("t1_busy_clear", {31'd0, busy_pending}, 32'd0);
    check_frame("t1", {7'h06, 7'h5B, 7'h77, 7'h71});

    // Load of 0000 while digit 1 is up: display holds until the boundary
    repeat (5) tick();
    do_load(16'h0000, 4'hF);
    check("t2_hold_seg", {25'd0, segments}, 32'h77);
    check("t2_hold_sel", {28'd0, digit_sel}, 32'h2);
    check("t2_busy", {31'd0, busy_pending}, 32'd1);
    wait_frame_done();
`ifdef LEADING_ZERO_BLANK_EN
    check_frame("t2", {7'h00, 7'h00, 7'h00, 7'h3F});
`else
    check_frame("t2", {7'h3F, 7'h3F, 7'h3F, 7'h3F});
`endif

    // Two loads in one frame: the last one wins
    repeat (2) tick();
    do_load(16'h1111, 4'hF);
    repeat (2) tick();
    do_load(16'h2222, 4'hF);
    check("t3_busy", {31'd0, busy_pending}, 32'd1);
    wait_frame_done();
    check_frame("t3", {7'h5B, 7'h5B, 7'h5B, 7'h5B});

    // Per-digit enable
    do_load(16'h8888, 4'b0101);
    wait_frame_done();
    check_frame("t4", {7'h00, 7'h7F, 7'h00, 7'h7F});

    // Load coincident with the frame boundary goes straight to display
    repeat (15) tick();
    do_load(16'h4321, 4'hF);
    check("t5_fd", {31'd0, frame_done}, 32'd1);
    check("t5_busy", {31'd0, busy_pending}, 32'd0);
    check_frame("t5", {7'h66, 7'h4F, 7'h5B, 7'h06});

    // Asynchronous reset mid-slot discards the pending load
    repeat (6) tick();
    do_load(16'h9999, 4'hF);
    check("t6_busy", {31'd0, busy_pending}, 32'd1);
    tick();
    check("t6_pre_sel", {28'd0, digit_sel}, 32'h2);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_seg",  {25'd0, segments}, 32'd0);
    check("t6_rst_sel",  {28'd0, digit_sel}, 32'd0);
    check("t6_rst_busy", {31'd0, busy_pending}, 32'd0);
    check("t6_rst_fd",   {31'd0, frame_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frame_done();
    check("t6_no_commit_busy", {31'd0, busy_pending}, 32'd0);
    check_frame("t6", {7'h00, 7'h00, 7'h00, 7'h00});

`ifdef LEADING_ZERO_BLANK_EN
    // Leading-zero blanking
    do_load(16'h0040, 4'hF);
    wait_frame_done();
    check_frame("lzb_40", {7'h00, 7'h00, 7'h66, 7'h3F});
    do_load(16'h0000, 4'hF);
    wait_frame_done();
    check_frame("lzb_0", {7'h00, 7'h00, 7'h00, 7'h3F});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
